// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths used by
// the requester and the memory slaves.
package apb_pkg;

   localparam int APB_ADD_WIDTH = 9;
   localparam int APB_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

endpackage

// File: rtl/apb_slave_mux.sv
// Slave select decode for a new command and the Pready/Prdata return path for
// the slave currently being accessed.
module apb_slave_mux #(
   parameter int WIDTH = 32
) (
   input  logic             dec_sel,
   output logic             dec_psel1,
   output logic             dec_psel2,
   input  logic             ret_sel,
   input  logic             Pready1,
   input  logic             Pready2,
   input  logic [WIDTH-1:0] Prdata1,
   input  logic [WIDTH-1:0] Prdata2,
   output logic             pready,
   output logic [WIDTH-1:0] prdata
);

   always_comb begin
      dec_psel1 = !dec_sel;
      dec_psel2 = dec_sel;
      pready    = ret_sel ? Pready2 : Pready1;
      prdata    = ret_sel ? Prdata2 : Prdata1;
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through IDLE/SETUP/ACCESS, two slaves
// decoded by the address MSB. Define APB_TIMEOUT_EN to abort stalled ACCESS.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADD_WIDTH = APB_ADD_WIDTH,
   parameter int WIDTH     = APB_WIDTH,
   parameter int TIMEOUT   = 16
) (
   input  logic                 Pclk,
   input  logic                 Presetn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADD_WIDTH-1:0] cmd_addr,
   input  logic [WIDTH-1:0]     cmd_wdata,
   input  logic [WIDTH/8-1:0]   cmd_strb,
   output logic                 rsp_valid,
   output logic [WIDTH-1:0]     rsp_rdata,
   output logic                 rsp_err,
   output logic                 Psel1,
   output logic                 Psel2,
   output logic                 Penable,
   output logic                 Pwrite,
   output logic [WIDTH/8-1:0]   Pstrb,
   output logic [ADD_WIDTH-2:0] Paddr,
   output logic [WIDTH-1:0]     Pwdata,
   input  logic [WIDTH-1:0]     Prdata1,
   input  logic [WIDTH-1:0]     Prdata2,
   input  logic                 Pready1,
   input  logic                 Pready2
);

   state_t           state_q, state_d;
   logic             accept, done, expired;
   logic             dec_psel1, dec_psel2;
   logic             pready;
   logic [WIDTH-1:0] prdata;

   // Psel2 is a registered, transfer-stable copy of the decoded slave index.
   apb_slave_mux #(.WIDTH(WIDTH)) u_mux (
      .dec_sel   (cmd_addr[ADD_WIDTH-1]),
      .dec_psel1 (dec_psel1),
      .dec_psel2 (dec_psel2),
      .ret_sel   (Psel2),
      .Pready1   (Pready1),
      .Pready2   (Pready2),
      .Prdata1   (Prdata1),
      .Prdata2   (Prdata2),
      .pready    (pready),
      .prdata    (prdata)
   );

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: the default assignment up front keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid)         state_d = SETUP;
         SETUP:                          state_d = ACCESS;
         ACCESS:  if (pready || expired) state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE);
      accept    = cmd_valid && cmd_ready;
      done      = (state_q == ACCESS) && (pready || expired);
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0] acc_cnt;

   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn)                 acc_cnt <= '0;
      else if (state_q == SETUP)    acc_cnt <= '0;
      else if (state_q == ACCESS)   acc_cnt <= acc_cnt + 1'b1;
   end

   // Expiry is judged on the last allowed ACCESS cycle; a Pready then still wins.
   assign expired = (state_q == ACCESS) && (acc_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign expired = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         Psel1     <= 1'b0;
         Psel2     <= 1'b0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Pstrb     <= '0;
         Paddr     <= '0;
         Pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         if (accept) begin
            Psel1  <= dec_psel1;
            Psel2  <= dec_psel2;
            Pwrite <= cmd_write;
            Paddr  <= cmd_addr[ADD_WIDTH-2:0];
            Pwdata <= cmd_wdata;
            Pstrb  <= cmd_write ? cmd_strb : '0;
         end
         if (state_q == SETUP) Penable <= 1'b1;
         if (done) begin
            Psel1     <= 1'b0;
            Psel2     <= 1'b0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (Pwrite || !pready) ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= !pready;
`endif
         end
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: two behavioural memory slaves with programmable wait
// states, a vector table, hand-written corner sequences and a response scoreboard.
module tb_apb_master;
   import apb_pkg::*;

   localparam int AW = APB_ADD_WIDTH;
   localparam int DW = APB_WIDTH;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic          Pclk, Presetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          Psel1, Psel2, Penable, Pwrite;
   logic [SW-1:0] Pstrb;
   logic [AW-2:0] Paddr;
   logic [DW-1:0] Pwdata, Prdata1, Prdata2;
   logic          Pready1, Pready2;

   apb_master #(.ADD_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
      .Pclk(Pclk), .Presetn(Presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .Psel1(Psel1), .Psel2(Psel2), .Penable(Penable), .Pwrite(Pwrite),
      .Pstrb(Pstrb), .Paddr(Paddr), .Pwdata(Pwdata),
      .Prdata1(Prdata1), .Prdata2(Prdata2), .Pready1(Pready1), .Pready2(Pready2)
   );

   initial Pclk = 1'b0;
   always #5 Pclk = ~Pclk;

   int cyc = 0;
   always @(posedge Pclk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave models: selected slave readies after slave_waits ACCESS cycles
   // (waits==1 ties Pready high, even in SETUP); the unselected one idles with Pready=1.
   logic [DW-1:0] mem1 [256];
   logic [DW-1:0] mem2 [256];
   int            slave_waits = 4;
   bit            slave_stuck = 1'b0;
   int            acc_cnt = 0;
   logic          sel_rdy;

   initial begin
      foreach (mem1[i]) mem1[i] = '0;
      foreach (mem2[i]) mem2[i] = '0;
   end

   always_comb begin
      sel_rdy = !slave_stuck && ((slave_waits == 1) || (Penable && acc_cnt == slave_waits - 1));
   end

   assign Pready1 = Psel1 ? sel_rdy : 1'b1;
   assign Pready2 = Psel2 ? sel_rdy : 1'b1;
   assign Prdata1 = mem1[Paddr];
   assign Prdata2 = mem2[Paddr];

   always @(posedge Pclk) begin
      if (Penable && !(Psel1 ? Pready1 : Pready2)) acc_cnt <= acc_cnt + 1;
      else                                         acc_cnt <= 0;
      if (Penable && Pwrite) begin
         for (int b = 0; b < SW; b++) begin
            if (Pstrb[b] && Psel1 && Pready1) mem1[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
            if (Pstrb[b] && Psel2 && Pready2) mem2[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
         end
      end
   end

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            cycle;
      int            waits;
   } exp_t;

   exp_t sb[$];

   // Response / protocol monitor, sampled on the falling edge.
   initial begin
      exp_t        e;
      int          pen_cnt = 0;
      logic [44:0] cap = '0;
      forever begin
         @(negedge Pclk);
         if (!Presetn) begin
            pen_cnt = 0;
         end else begin
            if (Penable) pen_cnt++;
            if (rsp_valid) begin
               if (sb.size() == 0) begin
                  check("rsp_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_rdata", rsp_rdata, e.rdata);
                  check("rsp_err", rsp_err, e.err);
                  check("rsp_cycle", cyc, e.cycle);
                  check("penable_cycles", pen_cnt, e.waits);
               end
               pen_cnt = 0;
            end
            if (cmd_ready) check("apb_idle_quiet", {Psel1, Psel2, Penable}, 3'b000);
            check("psel_onehot", Psel1 && Psel2, 0);
            if (Psel1 || Psel2) begin
               if (!Penable) cap = {Paddr, Pwrite, Pstrb, Pwdata};
               else          check("apb_stable", {Paddr, Pwrite, Pstrb, Pwdata}, cap);
            end
         end
      end
   end

   // Drives one command, queues its expected response and checks the SETUP cycle.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [DW-1:0] exp_rd, input logic exp_err,
                        input int waits, input bit hold, output int acc_cyc);
      int   bound = 0;
      exp_t e;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_strb  = st;
      while (!cmd_ready && bound < 200) begin
         @(negedge Pclk);
         bound++;
      end
      check("accept_wait", cmd_ready, 1);
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cycle = cyc + waits + 2;
      e.waits = waits;
      sb.push_back(e);
      acc_cyc = cyc + 1;
      @(posedge Pclk);
      #1;
      if (!hold) cmd_valid = 1'b0;
      @(negedge Pclk);
      check("setup_psel1", Psel1, !addr[AW-1]);
      check("setup_psel2", Psel2, addr[AW-1]);
      check("setup_penable", Penable, 0);
      check("setup_paddr", Paddr, addr[AW-2:0]);
      check("setup_pwrite", Pwrite, wr);
      check("setup_pstrb", Pstrb, wr ? st : '0);
      check("setup_pwdata", Pwdata, wd);
      check("setup_cmd_ready", cmd_ready, 0);
   endtask

   task automatic drain();
      int bound = 0;
      while (sb.size() != 0 && bound < 100) begin
         @(negedge Pclk);
         bound++;
      end
      check("drain", sb.size(), 0);
      @(negedge Pclk);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int a1, a2, a3;
      vecs[0] = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[1] = '{1'b0, 9'h005, 32'h0,        4'hF, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 9'h105, 32'hFFFFFFFF, 4'hF, 32'h0};
      vecs[3] = '{1'b1, 9'h105, 32'h11223344, 4'h3, 32'h0};
      vecs[4] = '{1'b0, 9'h105, 32'h0,        4'hF, 32'hFFFF3344};
      vecs[5] = '{1'b0, 9'h005, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 9'h1FF, 32'hA5A5A5A5, 4'hC, 32'h0};
      vecs[7] = '{1'b0, 9'h1FF, 32'h0,        4'hF, 32'hA5A50000};
      vecs[8] = '{1'b0, 9'h0FF, 32'h0,        4'hF, 32'h0};

      Presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      #1;
      check("reset_outputs", {Psel1, Psel2, Penable, Pwrite, rsp_valid, rsp_err}, 6'b0);
      check("reset_paddr", Paddr, 0);
      check("reset_pwdata", Pwdata, 0);
      check("reset_pstrb", Pstrb, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      repeat (2) @(negedge Pclk);
      Presetn = 1'b1;
      @(negedge Pclk);
      check("post_reset_ready", cmd_ready, 1);

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_rdata,
               1'b0, 4, 1'b0, a1);
         drain();
      end

      // Back-to-back with cmd_valid held: each accept lands in the previous rsp_valid cycle.
      issue(1'b1, 9'h010, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 4, 1'b1, a1);
      issue(1'b0, 9'h010, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 4, 1'b1, a2);
      issue(1'b0, 9'h110, 32'h0,        4'hF, 32'h0,        1'b0, 4, 1'b0, a3);
      check("b2b_period_1", a2 - a1, 6);
      check("b2b_period_2", a3 - a2, 6);
      drain();

      // Zero-wait slave: Pready tied high, including during SETUP.
      slave_waits = 1;
      issue(1'b1, 9'h120, 32'h12345678, 4'hF, 32'h0,        1'b0, 1, 1'b0, a1);
      drain();
      issue(1'b0, 9'h120, 32'h0,        4'hF, 32'h12345678, 1'b0, 1, 1'b0, a1);
      drain();
      slave_waits = 4;

      // Reset in the middle of ACCESS drops the transfer without a response.
      issue(1'b0, 9'h005, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 4, 1'b0, a1);
      @(negedge Pclk);
      check("mid_access_penable", Penable, 1);
      #2;
      Presetn = 1'b0;
      #1;
      check("async_reset_drop", {Psel1, Psel2, Penable, rsp_valid}, 4'b0);
      sb.delete();
      repeat (2) @(negedge Pclk);
      Presetn = 1'b1;
      repeat (8) @(negedge Pclk);
      check("after_reset_ready", cmd_ready, 1);

`ifdef APB_TIMEOUT_EN
      slave_stuck = 1'b1;
      issue(1'b0, 9'h005, 32'h0, 4'hF, 32'h0, 1'b1, TO, 1'b0, a1);
      drain();
      slave_stuck = 1'b0;
      issue(1'b0, 9'h005, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 4, 1'b0, a1);
      drain();
      slave_waits = TO;
      issue(1'b0, 9'h105, 32'h0, 4'hF, 32'hFFFF3344, 1'b0, TO, 1'b0, a1);
      drain();
      slave_waits = 4;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
